// File: rtl/fft_peak_detect.sv
// Squared-magnitude peak search over one FFT frame. The input is the serial bin stream.
// The strongest in-window bin is reported once per frame; a frame whose addresses break sequence is aborted.
module fft_peak_detect #(
  parameter int Nb        = 18,
  parameter int log_depth = 10,
  parameter int BIN_LO    = 1,
  parameter int BIN_HI    = 511
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bin_valid,
  input  logic [log_depth-1:0]   bin_addr,
  input  logic [Nb-1:0]          data_real,
  input  logic [Nb-1:0]          data_imag,
  input  logic [2*Nb-1:0]        mag_threshold,
  output logic                   peak_valid,
  output logic                   peak_found,
  output logic [log_depth-1:0]   peak_bin,
  output logic [2*Nb-1:0]        peak_mag,
  output logic                   frame_error,
  output logic                   busy,
  output logic                   dbg_state
);

  // Handshake: bin_valid is a one-way strobe with no ready. Every cycle with
  // bin_valid = 1 is consumed, and results come out as single-cycle pulses.
  typedef enum logic {WAIT_SOF = 1'b0, ACCUM = 1'b1} state_t;

  localparam logic [log_depth-1:0] ADDR_ZERO = '0;
  localparam logic [log_depth-1:0] ADDR_ONE  = log_depth'(1);
  localparam logic [log_depth-1:0] ADDR_LAST = '1;
  localparam logic [log_depth-1:0] WIN_LO    = log_depth'(BIN_LO);
  localparam logic [log_depth-1:0] WIN_HI    = log_depth'(BIN_HI);

  state_t                 state_q, state_d;
  logic [log_depth-1:0]   exp_q, exp_d;

  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_first_q, s1_first_d;
  logic                   s1_last_q, s1_last_d;
  logic                   s1_err_q, s1_err_d;
  logic [log_depth-1:0]   s1_addr_q, s1_addr_d;
  logic [2*Nb-1:0]        s1_re_sq_q, s1_re_sq_d;
  logic [2*Nb-1:0]        s1_im_sq_q, s1_im_sq_d;

  logic                   s2_valid_q, s2_valid_d;
  logic                   s2_first_q, s2_first_d;
  logic                   s2_last_q, s2_last_d;
  logic                   s2_err_q, s2_err_d;
  logic [log_depth-1:0]   s2_addr_q, s2_addr_d;
  logic [2*Nb-1:0]        s2_mag_q, s2_mag_d;

  logic [2*Nb-1:0]        max_q, max_d;
  logic [log_depth-1:0]   bin_q, bin_d;
  logic                   peak_valid_q, peak_valid_d;
  logic                   peak_found_q, peak_found_d;
  logic [log_depth-1:0]   peak_bin_q, peak_bin_d;
  logic [2*Nb-1:0]        peak_mag_q, peak_mag_d;
  logic                   frame_error_q, frame_error_d;

  // Sign-extend to full width so the product of the most-negative value comes out as +2^(2Nb-2).
  logic signed [2*Nb-1:0] re_ext, im_ext, re_sq, im_sq;
  assign re_ext = {{Nb{data_real[Nb-1]}}, data_real};
  assign im_ext = {{Nb{data_imag[Nb-1]}}, data_imag};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    s1_valid_d = 1'b0;
    s1_first_d = 1'b0;
    s1_last_d  = 1'b0;
    s1_err_d   = 1'b0;
    s1_addr_d  = bin_addr;
    s1_re_sq_d = re_sq;
    s1_im_sq_d = im_sq;
    if (bin_valid) begin
      case (state_q)
        WAIT_SOF: begin
          if (bin_addr == ADDR_ZERO) begin
            s1_valid_d = 1'b1;
            s1_first_d = 1'b1;
            exp_d      = ADDR_ONE;
            state_d    = ACCUM;
          end
        end
        ACCUM: begin
          if (bin_addr == exp_q) begin
            s1_valid_d = 1'b1;
            exp_d      = exp_q + ADDR_ONE;
            if (bin_addr == ADDR_LAST) begin
              s1_last_d = 1'b1;
              state_d   = WAIT_SOF;
            end
          end else if (bin_addr == ADDR_ZERO) begin
            s1_valid_d = 1'b1;
            s1_first_d = 1'b1;
            exp_d      = ADDR_ONE;
          end else begin
            s1_valid_d = 1'b1;
            s1_err_d   = 1'b1;
            state_d    = WAIT_SOF;
          end
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_first_d = s1_first_q;
    s2_last_d  = s1_last_q;
    s2_err_d   = s1_err_q;
    s2_addr_d  = s1_addr_q;
    s2_mag_d   = s1_re_sq_q + s1_im_sq_q;
  end

  // A frame-start tag reseeds the running max, so back-to-back frames never mix.
  logic [2*Nb-1:0]      base_mag, new_mag;
  logic [log_depth-1:0] base_bin, new_bin;
  logic                 in_win, take;

  always_comb begin
    base_mag      = s2_first_q ? '0 : max_q;
    base_bin      = s2_first_q ? WIN_LO : bin_q;
    in_win        = (s2_addr_q >= WIN_LO) && (s2_addr_q <= WIN_HI);
    take          = in_win && (s2_mag_q > base_mag);
    new_mag       = take ? s2_mag_q : base_mag;
    new_bin       = take ? s2_addr_q : base_bin;
    max_d         = max_q;
    bin_d         = bin_q;
    peak_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    peak_found_d  = peak_found_q;
    peak_bin_d    = peak_bin_q;
    peak_mag_d    = peak_mag_q;
    if (s2_valid_q) begin
      if (s2_err_q) begin
        frame_error_d = 1'b1;
      end else begin
        max_d = new_mag;
        bin_d = new_bin;
        if (s2_last_q) begin
          peak_valid_d = 1'b1;
          peak_bin_d   = new_bin;
          peak_mag_d   = new_mag;
          peak_found_d = new_mag > mag_threshold;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_SOF;
      exp_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_err_q      <= 1'b0;
      s1_addr_q     <= '0;
      s1_re_sq_q    <= '0;
      s1_im_sq_q    <= '0;
      s2_valid_q    <= 1'b0;
      s2_first_q    <= 1'b0;
      s2_last_q     <= 1'b0;
      s2_err_q      <= 1'b0;
      s2_addr_q     <= '0;
      s2_mag_q      <= '0;
      max_q         <= '0;
      bin_q         <= WIN_LO;
      peak_valid_q  <= 1'b0;
      peak_found_q  <= 1'b0;
      peak_bin_q    <= '0;
      peak_mag_q    <= '0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      s1_valid_q    <= s1_valid_d;
      s1_first_q    <= s1_first_d;
      s1_last_q     <= s1_last_d;
      s1_err_q      <= s1_err_d;
      s1_addr_q     <= s1_addr_d;
      s1_re_sq_q    <= s1_re_sq_d;
      s1_im_sq_q    <= s1_im_sq_d;
      s2_valid_q    <= s2_valid_d;
      s2_first_q    <= s2_first_d;
      s2_last_q     <= s2_last_d;
      s2_err_q      <= s2_err_d;
      s2_addr_q     <= s2_addr_d;
      s2_mag_q      <= s2_mag_d;
      max_q         <= max_d;
      bin_q         <= bin_d;
      peak_valid_q  <= peak_valid_d;
      peak_found_q  <= peak_found_d;
      peak_bin_q    <= peak_bin_d;
      peak_mag_q    <= peak_mag_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign peak_valid  = peak_valid_q;
  assign peak_found  = peak_found_q;
  assign peak_bin    = peak_bin_q;
  assign peak_mag    = peak_mag_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q == ACCUM);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect. It uses table-driven spike frames, hand-written corner sequences,
// and random frames checked against an argmax reference model and a pulse scoreboard.
module tb_fft_peak_detect;

  localparam int N      = 1024;
  localparam int NB     = 18;
  localparam int LD     = 10;
  localparam int BIN_LO = 1;
  localparam int BIN_HI = 511;

  logic            clk = 1'b0;
  logic            reset;
  logic            bin_valid;
  logic [LD-1:0]   bin_addr;
  logic [NB-1:0]   data_real, data_imag;
  logic [2*NB-1:0] mag_threshold;
  logic            peak_valid, peak_found, frame_error, busy, dbg_state;
  logic [LD-1:0]   peak_bin;
  logic [2*NB-1:0] peak_mag;

  fft_peak_detect #(.Nb(NB), .log_depth(LD), .BIN_LO(BIN_LO), .BIN_HI(BIN_HI)) dut (
    .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_addr(bin_addr),
    .data_real(data_real), .data_imag(data_imag), .mag_threshold(mag_threshold),
    .peak_valid(peak_valid), .peak_found(peak_found), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .frame_error(frame_error), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int last_cyc;
  int fr_re[N];
  int fr_im[N];

  // scoreboard: {cycle[31:0], bin[9:0], mag[35:0], found}
  logic [78:0] exp_q[$];
  logic [31:0] err_q[$];

  typedef struct {
    int          bin;
    int          re;
    int          im;
    logic [35:0] thr;
    int          exp_bin;
    logic [35:0] exp_mag;
    bit          exp_found;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [78:0] pack(input int c, input int b, input logic [35:0] m, input bit f);
    return {32'(c), 10'(b), m, f};
  endfunction

  // Reference: strict argmax of re^2+im^2 over the search window, lowest index on ties.
  function automatic logic [78:0] model(input logic [35:0] thr, input int c);
    longint best = 0;
    int     bb = BIN_LO;
    for (int a = BIN_LO; a <= BIN_HI; a++) begin
      longint m = longint'(fr_re[a]) * fr_re[a] + longint'(fr_im[a]) * fr_im[a];
      if (m > best) begin
        best = m;
        bb = a;
      end
    end
    return pack(c, bb, 36'(best), best > longint'(thr));
  endfunction

  // driver tasks
  task automatic drive(input bit v, input int a, input int re, input int im);
    @(posedge clk);
    #1;
    bin_valid = v;
    bin_addr  = LD'(a);
    data_real = NB'(re);
    data_imag = NB'(im);
    last_cyc  = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 0);
  endtask

  task automatic clear_frame();
    for (int a = 0; a < N; a++) begin
      fr_re[a] = 0;
      fr_im[a] = 0;
    end
  endtask

  task automatic random_frame(input int span);
    for (int a = 0; a < N; a++) begin
      fr_re[a] = int'($urandom_range(0, 2 * span)) - span;
      fr_im[a] = int'($urandom_range(0, 2 * span)) - span;
    end
  endtask

  task automatic send_frame(input int max_gap, output int lc);
    for (int a = 0; a < N; a++) begin
      drive(1'b1, a, fr_re[a], fr_im[a]);
      lc = last_cyc;
      if (a == 5) check("busy_mid_frame", busy, 1);
      if (max_gap > 0 && a < N - 1) idle(int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || err_q.size() != 0); i++) idle(1);
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_pulse: %0d peak and %0d error pulses outstanding", exp_q.size(), err_q.size());
      exp_q.delete();
      err_q.delete();
    end
  endtask

  task automatic monitor();
    logic [78:0] e;
    logic [31:0] ec;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (peak_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_peak_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("peak_cycle", cyc, e[78:47]);
            check("peak_bin", peak_bin, e[46:37]);
            check("peak_mag", peak_mag, e[36:1]);
            check("peak_found", peak_found, e[0]);
          end
        end
        if (frame_error) begin
          if (err_q.size() == 0) begin
            check("unexpected_frame_error", 1, 0);
          end else begin
            ec = err_q.pop_front();
            check("error_cycle", cyc, ec);
          end
        end
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_peak_valid"}, peak_valid, 0);
    check({tag, "_peak_found"}, peak_found, 0);
    check({tag, "_peak_bin"}, peak_bin, 0);
    check({tag, "_peak_mag"}, peak_mag, 0);
    check({tag, "_frame_error"}, frame_error, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int lc, lc2;
    logic [35:0] thr;
    tbl[0] = '{37, 3000, -4000, 36'd1000, 37, 36'd25000000, 1'b1};
    tbl[1] = '{12, -131072, 0, 36'd0, 12, 36'd17179869184, 1'b1};
    tbl[2] = '{511, 100, 100, 36'd20000, 511, 36'd20000, 1'b0};
    tbl[3] = '{1, -1, 0, 36'd0, 1, 36'd1, 1'b1};
    tbl[4] = '{0, 5000, 5000, 36'd0, 1, 36'd0, 1'b0};
    tbl[5] = '{512, 7, 7, 36'd0, 1, 36'd0, 1'b0};
    tbl[6] = '{200, -131072, -131072, 36'd34359738367, 200, 36'd34359738368, 1'b1};

    reset = 1'b1;
    bin_valid = 1'b0;
    bin_addr = '0;
    data_real = '0;
    data_imag = '0;
    mag_threshold = '0;
    fork monitor(); join_none
    @(posedge clk);
    #1;
    check_cleared("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(100);
    check_cleared("idle");

    // table-driven single-spike frames
    foreach (tbl[i]) begin
      clear_frame();
      fr_re[tbl[i].bin] = tbl[i].re;
      fr_im[tbl[i].bin] = tbl[i].im;
      mag_threshold = tbl[i].thr;
      send_frame(0, lc);
      exp_q.push_back(pack(lc + 3, tbl[i].exp_bin, tbl[i].exp_mag, tbl[i].exp_found));
      idle(1);
      check("busy_after_frame", busy, 0);
      wait_drain();
    end

    // DC and mirrored bins ignored
    clear_frame();
    fr_re[0] = 131071;
    fr_re[700] = 131071;
    fr_re[12] = -131072;
    mag_threshold = 36'd0;
    send_frame(0, lc);
    exp_q.push_back(pack(lc + 3, 12, 36'd17179869184, 1'b1));
    wait_drain();

    // tie keeps lower index, random gaps between bins
    clear_frame();
    fr_re[50] = 300; fr_im[50] = 400;
    fr_re[60] = 400; fr_im[60] = -300;
    mag_threshold = 36'd249999;
    send_frame(3, lc);
    exp_q.push_back(pack(lc + 3, 50, 36'd250000, 1'b1));
    wait_drain();

    // address break at 101
    random_frame(1000);
    for (int a = 0; a < 100; a++) drive(1'b1, a, fr_re[a], fr_im[a]);
    drive(1'b1, 101, 5, 5);
    err_q.push_back(last_cyc + 3);
    idle(1);
    check("busy_after_error", busy, 0);
    for (int a = 102; a < 110; a++) drive(1'b1, a, 9, 9);
    wait_drain();
    thr = 36'(longint'($urandom_range(0, 2000000)));
    mag_threshold = thr;
    send_frame(0, lc);
    exp_q.push_back(model(thr, lc + 3));
    wait_drain();

    // reset mid-frame, then a clean frame
    random_frame(131071);
    for (int a = 0; a <= 500; a++) drive(1'b1, a, fr_re[a], fr_im[a]);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bin_valid = 1'b0;
    #1;
    check_cleared("midframe_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(10);
    thr = 36'(longint'($urandom_range(0, 32'hFFFF_FFFF))) << 2;
    mag_threshold = thr;
    send_frame(0, lc);
    exp_q.push_back(model(thr, lc + 3));
    wait_drain();

    // back-to-back frames, no idle between
    mag_threshold = 36'd6;
    random_frame(2);
    send_frame(0, lc);
    exp_q.push_back(model(36'd6, lc + 3));
    random_frame(131071);
    fr_re[BIN_HI] = -131072;
    fr_im[BIN_HI] = -131072;
    send_frame(0, lc2);
    exp_q.push_back(model(36'd6, lc2 + 3));
    wait_drain();

    // random frames with gaps
    for (int k = 0; k < 2; k++) begin
      random_frame(k == 0 ? 3 : 131071);
      thr = (k == 0) ? 36'(longint'($urandom_range(0, 12))) : 36'(longint'($urandom_range(0, 32'hFFFF_FFFF)));
      mag_threshold = thr;
      send_frame(2, lc);
      exp_q.push_back(model(thr, lc + 3));
      wait_drain();
    end

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
